sha256_round_ctrl: RTL and testbench
====================================

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 64, rounds per block; fixed at 64 for SHA-256, other values unsupported.
REQ-002 Parameter CNT_W, default 16, width of the block counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init  input  1  one-cycle request: start new message (first block, load initial hash).
REQ-006 next  input  1  one-cycle request: process following block of current message.
REQ-007 ready  output  1  high when idle and able to accept init/next.
REQ-008 hash_init  output  1  one-cycle pulse: load H0..H7 initial constants.
REQ-009 wmem_load  output  1  one-cycle pulse: load 512-bit block into message schedule.
REQ-010 round_en  output  1  high during every compression round cycle.
REQ-011 round_idx  output  6  current round number, 0..63.
REQ-012 digest_update  output  1  one-cycle pulse: add working variables into H.
REQ-013 digest_valid  output  1  high while digest reflects all blocks accepted so far.
REQ-014 block_cnt  output  CNT_W  blocks completed since last init.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, ROUNDS, DIGEST.
REQ-016 IDLE: ready=1, round_idx=0, round_en=0; init or next sampled high -> LOAD on next edge.
REQ-017 init and next both high in IDLE: SHALL be treated as init.
REQ-018 init/next while not in IDLE SHALL be ignored with no side effect.
REQ-019 LOAD (1 cycle): wmem_load=1; hash_init=1 only if entry was via init; ready=0; -> ROUNDS.
REQ-020 ROUNDS: round_en=1; round_idx starts 0, increments by 1 each cycle; at round_idx==63 -> DIGEST; round_idx returns to 0.
REQ-021 DIGEST (1 cycle): digest_update=1, round_en=0; -> IDLE.
REQ-022 Latency: request sampled at edge T -> LOAD in cycle T+1, rounds 0..63 in cycles T+2..T+65, DIGEST in T+66, ready=1 and digest_valid=1 in T+67.
REQ-023 digest_valid SHALL clear on the edge a request is accepted and set on the edge leaving DIGEST.
REQ-024 block_cnt SHALL clear to 0 when init is accepted and increment by 1 on leaving DIGEST; wraps from all-ones to 0.
REQ-025 next accepted with digest_valid=0 and block_cnt=0 (no prior init) SHALL still run normally; no error flag.
REQ-026 All pulse outputs (hash_init, wmem_load, digest_update) SHALL be registered, exactly one cycle wide, and mutually exclusive in time.
REQ-027 round_idx SHALL never exceed 63.

Reset
REQ-028 reset high at any edge SHALL force IDLE, round_idx=0, block_cnt=0, digest_valid=0, all pulses 0, ready=1 on the following cycle.
REQ-029 reset mid-operation SHALL abort the block without issuing digest_update.
REQ-030 reset SHALL take priority over simultaneous init/next.

Structure
REQ-031 State encoding, NUM_ROUNDS and the last-round index constant SHALL live in the shared sha256 package.
REQ-032 No sub-module required; the round counter is inline in the FSM block.

Verification
REQ-033 Reset, then init at cycle 10 -> hash_init+wmem_load at 11, round_en 12..75 with round_idx 0..63, digest_update at 76, ready/digest_valid=1 and block_cnt=1 at 77.
REQ-034 init then next after completion -> second block has hash_init=0, wmem_load=1; block_cnt=2 at end.
REQ-035 init and next both asserted in IDLE -> hash_init=1, block_cnt cleared then 1.
REQ-036 init pulsed during ROUNDS at round_idx=30 -> ignored; round_idx continues 31..63, single digest_update.
REQ-037 reset asserted at round_idx=40 -> next cycle IDLE, round_idx=0, no digest_update, digest_valid=0.
REQ-038 Force block_cnt to 0xFFFF then complete a next block -> block_cnt=0x0000.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round controller.
// Holds the FSM encoding, the round count and the last-round index.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROUNDS = 2'd2,
        ST_DIGEST = 2'd3
    } round_state_t;

    localparam int          SHA256_ROUNDS  = 64;
    localparam int          ROUND_IDX_W    = 6;
    localparam logic [5:0]  LAST_ROUND_IDX = 6'd63;

    function automatic logic is_last_round(input logic [ROUND_IDX_W-1:0] idx);
        return (idx == LAST_ROUND_IDX);
    endfunction

endpackage

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: LOAD -> 64 compression rounds -> DIGEST.
// Every output is a register so downstream datapath sees glitch-free controls.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = SHA256_ROUNDS,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic                   next,
    output logic                   ready,
    output logic                   hash_init,
    output logic                   wmem_load,
    output logic                   round_en,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   digest_update,
    output logic                   digest_valid,
    output logic [CNT_W-1:0]       block_cnt
);

    if (NUM_ROUNDS != SHA256_ROUNDS) begin : g_bad_rounds
        $error("sha256_round_ctrl supports only 64 rounds per block");
    end

    round_state_t           r_state;
    logic                   r_ready;
    logic                   r_hash_init;
    logic                   r_wmem_load;
    logic                   r_round_en;
    logic [ROUND_IDX_W-1:0] r_round_idx;
    logic                   r_digest_update;
    logic                   r_digest_valid;
    logic [CNT_W-1:0]       r_block_cnt;

    // Sequencer with inline round counter; outputs are set on the edge entering each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_ready         <= 1'b1;
            r_hash_init     <= 1'b0;
            r_wmem_load     <= 1'b0;
            r_round_en      <= 1'b0;
            r_round_idx     <= 6'd0;
            r_digest_update <= 1'b0;
            r_digest_valid  <= 1'b0;
            r_block_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init || next) begin
                        // init wins when both are raised together
                        r_state        <= ST_LOAD;
                        r_ready        <= 1'b0;
                        r_wmem_load    <= 1'b1;
                        r_hash_init    <= init;
                        r_digest_valid <= 1'b0;
                        if (init) begin
                            r_block_cnt <= '0;
                        end else begin
                            r_block_cnt <= r_block_cnt;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_state     <= ST_ROUNDS;
                    r_wmem_load <= 1'b0;
                    r_hash_init <= 1'b0;
                    r_round_en  <= 1'b1;
                    r_round_idx <= 6'd0;
                end
                ST_ROUNDS: begin
                    if (is_last_round(r_round_idx)) begin
                        r_state         <= ST_DIGEST;
                        r_round_en      <= 1'b0;
                        r_round_idx     <= 6'd0;
                        r_digest_update <= 1'b1;
                    end else begin
                        r_round_idx <= r_round_idx + 6'd1;
                    end
                end
                ST_DIGEST: begin
                    r_state         <= ST_IDLE;
                    r_digest_update <= 1'b0;
                    r_ready         <= 1'b1;
                    r_digest_valid  <= 1'b1;
                    r_block_cnt     <= r_block_cnt + CNT_W'(1);
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_ready         <= 1'b1;
                    r_hash_init     <= 1'b0;
                    r_wmem_load     <= 1'b0;
                    r_round_en      <= 1'b0;
                    r_round_idx     <= 6'd0;
                    r_digest_update <= 1'b0;
                    r_digest_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign ready         = r_ready;
    assign hash_init     = r_hash_init;
    assign wmem_load     = r_wmem_load;
    assign round_en      = r_round_en;
    assign round_idx     = r_round_idx;
    assign digest_update = r_digest_update;
    assign digest_valid  = r_digest_valid;
    assign block_cnt     = r_block_cnt;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl; a second, 2-bit-counter instance
// shares the stimulus so the block counter wrap can be reached quickly.
module tb_sha256_round_ctrl;

    logic        clk;
    logic        reset;
    logic        init;
    logic        next;

    logic        ready, hash_init, wmem_load, round_en, digest_update, digest_valid;
    logic [5:0]  round_idx;
    logic [15:0] block_cnt;

    logic        w2_ready, w2_hash_init, w2_wmem_load, w2_round_en, w2_digest_update, w2_digest_valid;
    logic [5:0]  w2_round_idx;
    logic [1:0]  w2_block_cnt;

    int n_checks = 0;
    int n_errors = 0;

    sha256_round_ctrl #(.NUM_ROUNDS(64), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .init(init), .next(next),
        .ready(ready), .hash_init(hash_init), .wmem_load(wmem_load),
        .round_en(round_en), .round_idx(round_idx), .digest_update(digest_update),
        .digest_valid(digest_valid), .block_cnt(block_cnt)
    );

    sha256_round_ctrl #(.NUM_ROUNDS(64), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .init(init), .next(next),
        .ready(w2_ready), .hash_init(w2_hash_init), .wmem_load(w2_wmem_load),
        .round_en(w2_round_en), .round_idx(w2_round_idx), .digest_update(w2_digest_update),
        .digest_valid(w2_digest_valid), .block_cnt(w2_block_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_valid, input logic [15:0] exp_cnt);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_round_idx"}, {26'd0, round_idx}, 32'd0);
        chk({tag, "_round_en"}, {31'd0, round_en}, 32'd0);
        chk({tag, "_pulses"}, {29'd0, hash_init, wmem_load, digest_update}, 32'd0);
        chk({tag, "_digest_valid"}, {31'd0, digest_valid}, {31'd0, exp_valid});
        chk({tag, "_block_cnt"}, {16'd0, block_cnt}, {16'd0, exp_cnt});
    endtask

    // One full block; inj_at >= 0 raises init during that round to prove it is ignored.
    task automatic run_block(input string tag, input logic i_init, input logic i_next,
                             input logic exp_hi, input logic [15:0] exp_cnt, input int inj_at);
        int n_digest;
        n_digest = 0;
        init = i_init;
        next = i_next;
        step();
        init = 1'b0;
        next = 1'b0;
        chk({tag, "_load_wmem"}, {31'd0, wmem_load}, 32'd1);
        chk({tag, "_load_hinit"}, {31'd0, hash_init}, {31'd0, exp_hi});
        chk({tag, "_load_ready"}, {31'd0, ready}, 32'd0);
        chk({tag, "_load_valid"}, {31'd0, digest_valid}, 32'd0);
        chk({tag, "_load_ren"}, {31'd0, round_en}, 32'd0);
        step();
        for (int r = 0; r < 64; r++) begin
            chk({tag, "_round_en"}, {31'd0, round_en}, 32'd1);
            chk({tag, "_round_idx"}, {26'd0, round_idx}, r);
            chk({tag, "_round_pulses"}, {29'd0, hash_init, wmem_load, ready}, 32'd0);
            if (digest_update) n_digest++;
            if (r == inj_at) init = 1'b1;
            step();
            init = 1'b0;
        end
        chk({tag, "_dig_update"}, {31'd0, digest_update}, 32'd1);
        chk({tag, "_dig_ren"}, {31'd0, round_en}, 32'd0);
        chk({tag, "_dig_ready"}, {31'd0, ready}, 32'd0);
        chk({tag, "_dig_others"}, {30'd0, hash_init, wmem_load}, 32'd0);
        n_digest++;
        step();
        chk({tag, "_digest_count"}, n_digest, 32'd1);
        chk_idle({tag, "_end"}, 1'b1, exp_cnt);
        chk({tag, "_w2_cnt"}, {30'd0, w2_block_cnt}, {30'd0, exp_cnt[1:0]});
    endtask

    initial begin
        reset = 1'b1;
        init  = 1'b0;
        next  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk_idle("reset", 1'b0, 16'd0);
        repeat (6) step();
        chk_idle("idle_hold", 1'b0, 16'd0);

        run_block("init_blk", 1'b1, 1'b0, 1'b1, 16'd1, -1);
        run_block("next_blk", 1'b0, 1'b1, 1'b0, 16'd2, -1);
        run_block("both_blk", 1'b1, 1'b1, 1'b1, 16'd1, -1);
        run_block("inj_blk", 1'b0, 1'b1, 1'b0, 16'd2, 30);
        run_block("cnt3_blk", 1'b0, 1'b1, 1'b0, 16'd3, -1);
        run_block("wrap_blk", 1'b0, 1'b1, 1'b0, 16'd4, -1);

        // Abort at round 40
        next = 1'b1;
        step();
        next = 1'b0;
        step();
        repeat (40) step();
        chk("abort_idx", {26'd0, round_idx}, 32'd40);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("abort", 1'b0, 16'd0);
        for (int k = 0; k < 30; k++) begin
            chk("abort_no_digest", {31'd0, digest_update}, 32'd0);
            step();
        end

        // Reset beats a simultaneous init
        reset = 1'b1;
        init  = 1'b1;
        step();
        reset = 1'b0;
        init  = 1'b0;
        chk_idle("rst_prio", 1'b0, 16'd0);
        step();
        chk_idle("rst_prio2", 1'b0, 16'd0);

        // next with no prior init runs normally
        run_block("orphan_next", 1'b0, 1'b1, 1'b0, 16'd1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
